vga_console: RTL and testbench

Character-stream front end for the 80x60 text VGA display: accepts one 7-bit ASCII code at a time over a valid/ready handshake, tracks a cursor, and issues single-cell writes into the display's character RAM. It interprets newline, carriage return, backspace and form feed, and scrolls the screen up one row when output runs past the last row. It sits directly upstream of the text VGA stage and drives that stage's character-RAM write port (write enable, cell address, data); it reads cells back through the stage's asynchronous read port.

---
 rtl/vga_console_pkg.sv | 39 +++
 rtl/vga_console_addr.sv | 13 +
 rtl/vga_console.sv | 219 +++++++++++++++++++++
 tb/tb_vga_console.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_console_pkg.sv
// Shared constants, state encoding and RAM-port payload for the text console front end.
package vga_console_pkg;

    localparam int unsigned COLS         = 80;
    localparam int unsigned ROWS         = 60;
    localparam int unsigned CELLS        = COLS * ROWS;
    localparam int unsigned SCROLL_CELLS = CELLS - COLS;
    localparam int unsigned ADDR_W       = 13;
    localparam int unsigned ROW_W        = 6;
    localparam int unsigned COL_W        = 7;
    localparam int unsigned CHAR_W       = 7;

    localparam logic [CHAR_W-1:0] ASCII_BS    = 7'h08;
    localparam logic [CHAR_W-1:0] ASCII_LF    = 7'h0A;
    localparam logic [CHAR_W-1:0] ASCII_FF    = 7'h0C;
    localparam logic [CHAR_W-1:0] ASCII_CR    = 7'h0D;
    localparam logic [CHAR_W-1:0] ASCII_SPACE = 7'h20;
    localparam logic [CHAR_W-1:0] ASCII_TILDE = 7'h7E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_SCR_RD,
        ST_SCR_WR,
        ST_CLR
    } state_e;

    // One cycle's worth of character-RAM port activity.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [CHAR_W-1:0] wdata;
    } vram_req_t;

    function automatic logic is_printable(input logic [CHAR_W-1:0] c);
        return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
    endfunction

endpackage

// File: rtl/vga_console_addr.sv
// Combinational (row, col) -> linear cell index, row*80 built from two shifts.
module vga_console_addr
    import vga_console_pkg::*;
(
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] cell_c
);

    // row*64 + row*16 + col
    assign cell_c = (ADDR_W'(row) << 6) + (ADDR_W'(row) << 4) + ADDR_W'(col);

endmodule

// File: rtl/vga_console.sv
// Character-stream front end: cursor tracking, control-code handling, scroll and clear
// sequencing, all driving the text display's character-RAM port.
module vga_console
    import vga_console_pkg::*;
(
    input  logic              sys_clk,
    input  logic              clrn,
    input  logic              char_valid,
    input  logic [6:0]        char_data,
    output logic              char_ready,
    output logic              vram_we,
    output logic [12:0]       vram_addr,
    output logic [6:0]        vram_wdata,
    input  logic [6:0]        vram_rdata,
    output logic [5:0]        cur_row,
    output logic [6:0]        cur_col,
    output logic              busy
);

    localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL    = COL_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_SHIFT  = ADDR_W'(SCROLL_CELLS - 1);
    localparam logic [ADDR_W-1:0] FIRST_BLANK = ADDR_W'(SCROLL_CELLS);
    localparam logic [ADDR_W-1:0] LAST_CELL   = ADDR_W'(CELLS - 1);

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [CHAR_W-1:0]   latch_q, latch_d;
    logic [CHAR_W-1:0]   code_q, code_d;
    logic                adv_q, adv_d;
    logic [ADDR_W-1:0]   cell_d;
    vram_req_t           req_q, req_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;

    // Cell index of the cursor position the next cycle will use.
    vga_console_addr u_addr (
        .row    (row_d),
        .col    (col_d),
        .cell_c (cell_d)
    );

    // State register.
    always_ff @(posedge sys_clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Cursor, cell counter, read latch and pending write code.
    always_ff @(posedge sys_clk or negedge clrn) begin
        if (!clrn) begin
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            latch_q <= '0;
            code_q  <= '0;
            adv_q   <= 1'b0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            code_q  <= code_d;
            adv_q   <= adv_d;
        end
    end

    // Next state and datapath updates; only IDLE accepts codes.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        latch_d = latch_q;
        code_d  = code_q;
        adv_d   = adv_q;
        case (state_q)
            ST_IDLE: begin
                if (char_valid) begin
                    if (is_printable(char_data)) begin
                        state_d = ST_WRITE;
                        code_d  = char_data;
                        adv_d   = 1'b1;
                    end else begin
                        case (char_data)
                            ASCII_LF: begin
                                col_d = '0;
                                if (row_q == LAST_ROW) begin
                                    state_d = ST_SCR_RD;
                                    cnt_d   = '0;
                                end else begin
                                    row_d = row_q + ROW_W'(1);
                                end
                            end
                            ASCII_CR: begin
                                col_d = '0;
                            end
                            ASCII_BS: begin
                                if (col_q != '0) begin
                                    col_d   = col_q - COL_W'(1);
                                    state_d = ST_WRITE;
                                    code_d  = ASCII_SPACE;
                                    adv_d   = 1'b0;
                                end
                            end
                            ASCII_FF: begin
                                row_d   = '0;
                                col_d   = '0;
                                cnt_d   = '0;
                                state_d = ST_CLR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                if (adv_q) begin
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            state_d = ST_SCR_RD;
                            cnt_d   = '0;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            ST_SCR_RD: begin
                latch_d = vram_rdata;
                state_d = ST_SCR_WR;
            end
            ST_SCR_WR: begin
                if (cnt_q == LAST_SHIFT) begin
                    cnt_d   = FIRST_BLANK;
                    state_d = ST_CLR;
                end else begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                    state_d = ST_SCR_RD;
                end
            end
            ST_CLR: begin
                if (cnt_q == LAST_CELL) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Port values for the coming cycle, derived from the next state so they can be registered.
    always_comb begin
        req_d   = '0;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
            end
            ST_WRITE: begin
                req_d.we    = 1'b1;
                req_d.addr  = cell_d;
                req_d.wdata = code_d;
            end
            ST_SCR_RD: begin
                req_d.addr = cnt_d + ADDR_W'(COLS);
                busy_d     = 1'b1;
            end
            ST_SCR_WR: begin
                req_d.we    = 1'b1;
                req_d.addr  = cnt_d;
                req_d.wdata = latch_d;
                busy_d      = 1'b1;
            end
            ST_CLR: begin
                req_d.we    = 1'b1;
                req_d.addr  = cnt_d;
                req_d.wdata = ASCII_SPACE;
                busy_d      = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered RAM port and status outputs.
    always_ff @(posedge sys_clk or negedge clrn) begin
        if (!clrn) begin
            req_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            req_q   <= req_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign char_ready = ready_q;
    assign busy       = busy_q;
    assign vram_we    = req_q.we;
    assign vram_addr  = req_q.addr;
    assign vram_wdata = req_q.wdata;
    assign cur_row    = row_q;
    assign cur_col    = col_q;

endmodule

// File: tb/tb_vga_console.sv
// Scoreboard bench for vga_console: a screen-level model predicts every RAM write,
// handshake stall length and busy length; a negedge monitor checks them as they occur.
module tb_vga_console;

    localparam int CELLS  = 4800;
    localparam int SHIFT  = 4720;
    localparam int SCROLL = 2 * 4720 + 80;

    logic        sys_clk = 1'b0;
    logic        clrn = 1'b0;
    logic        char_valid = 1'b0;
    logic [6:0]  char_data = 7'h00;
    logic        char_ready;
    logic        vram_we;
    logic [12:0] vram_addr;
    logic [6:0]  vram_wdata;
    logic [6:0]  vram_rdata;
    logic [5:0]  cur_row;
    logic [6:0]  cur_col;
    logic        busy;

    vga_console dut (
        .sys_clk    (sys_clk),
        .clrn       (clrn),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata),
        .cur_row    (cur_row),
        .cur_col    (cur_col),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Character RAM seen by the DUT: async read, write on posedge.
    logic [6:0] tb_ram [CELLS];
    assign vram_rdata = (int'(vram_addr) < CELLS) ? tb_ram[int'(vram_addr)] : 7'h00;
    always @(posedge sys_clk) begin
        if (clrn && vram_we && int'(vram_addr) < CELLS) tb_ram[int'(vram_addr)] <= vram_wdata;
    end

    // Reference screen and cursor.
    logic [6:0] ref_mem [CELLS];
    int ref_row = 0;
    int ref_col = 0;

    typedef struct { int addr; int data; } wr_t;
    wr_t exp_wr[$];
    int  exp_ready_run[$];
    int  exp_busy_run[$];

    int tests = 0;
    int fails = 0;
    int ready_low = 0;
    int busy_cnt = 0;
    wr_t mon_e;
    int  mon_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input int v);
        tests++;
        fails++;
        $display("FAIL %s: value %0d with nothing expected", name, v);
    endtask

    // Monitor: every write, every not-ready stretch, every busy stretch is matched in order.
    always @(negedge sys_clk) begin
        if (!clrn) begin
            ready_low = 0;
            busy_cnt  = 0;
        end else begin
            if (vram_we) begin
                if (exp_wr.size() == 0) flag("unexpected_write", int'(vram_addr));
                else begin
                    mon_e = exp_wr.pop_front();
                    chk("wr_addr", 32'(vram_addr), 32'(mon_e.addr));
                    chk("wr_data", 32'(vram_wdata), 32'(mon_e.data));
                end
            end
            if (!char_ready) ready_low++;
            else if (ready_low > 0) begin
                if (exp_ready_run.size() == 0) flag("unexpected_stall", ready_low);
                else begin
                    mon_n = exp_ready_run.pop_front();
                    chk("ready_low_cycles", 32'(ready_low), 32'(mon_n));
                end
                ready_low = 0;
            end
            if (busy) busy_cnt++;
            else if (busy_cnt > 0) begin
                if (exp_busy_run.size() == 0) flag("unexpected_busy", busy_cnt);
                else begin
                    mon_n = exp_busy_run.pop_front();
                    chk("busy_cycles", 32'(busy_cnt), 32'(mon_n));
                end
                busy_cnt = 0;
            end
        end
    end

    function automatic void push_wr(input int a, input int d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endfunction

    // Scroll as the screen sees it: every row moves up one, the last row is blanked.
    function automatic void ref_scroll();
        for (int i = 0; i < SHIFT; i++) begin
            ref_mem[i] = ref_mem[i + 80];
            push_wr(i, int'(ref_mem[i]));
        end
        for (int i = SHIFT; i < CELLS; i++) begin
            ref_mem[i] = 7'h20;
            push_wr(i, 32);
        end
        exp_busy_run.push_back(SCROLL);
    endfunction

    function automatic void model(input logic [6:0] c);
        int run;
        if (c >= 7'h20 && c <= 7'h7E) begin
            push_wr(ref_row * 80 + ref_col, int'(c));
            ref_mem[ref_row * 80 + ref_col] = c;
            run = 1;
            ref_col++;
            if (ref_col == 80) begin
                ref_col = 0;
                if (ref_row == 59) begin
                    ref_scroll();
                    run += SCROLL;
                end else ref_row++;
            end
            exp_ready_run.push_back(run);
        end else if (c == 7'h0A) begin
            ref_col = 0;
            if (ref_row == 59) begin
                ref_scroll();
                exp_ready_run.push_back(SCROLL);
            end else ref_row++;
        end else if (c == 7'h0D) begin
            ref_col = 0;
        end else if (c == 7'h08) begin
            if (ref_col > 0) begin
                ref_col--;
                push_wr(ref_row * 80 + ref_col, 32);
                ref_mem[ref_row * 80 + ref_col] = 7'h20;
                exp_ready_run.push_back(1);
            end
        end else if (c == 7'h0C) begin
            ref_row = 0;
            ref_col = 0;
            for (int i = 0; i < CELLS; i++) begin
                ref_mem[i] = 7'h20;
                push_wr(i, 32);
            end
            exp_ready_run.push_back(CELLS);
            exp_busy_run.push_back(CELLS);
        end
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!char_ready && n < 20000) begin
            @(negedge sys_clk);
            n++;
        end
        if (!char_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: char_ready still %0b after %0d cycles, required 1", char_ready, n);
        end
    endtask

    task automatic send(input logic [6:0] c);
        wait_ready();
        char_valid = 1'b1;
        char_data  = c;
        model(c);
        @(negedge sys_clk);
        char_valid = 1'b0;
    endtask

    // Raise valid before the block is ready and hold it until it is taken.
    task automatic send_held(input logic [6:0] c);
        char_valid = 1'b1;
        char_data  = c;
        wait_ready();
        model(c);
        @(negedge sys_clk);
        char_valid = 1'b0;
    endtask

    task automatic check_cursor(input int r, input int c);
        wait_ready();
        chk("cur_row", 32'(cur_row), 32'(r));
        chk("cur_col", 32'(cur_col), 32'(c));
    endtask

    task automatic check_screen();
        int bad = 0;
        for (int i = 0; i < CELLS; i++) if (tb_ram[i] !== ref_mem[i]) bad++;
        chk("screen_mismatches", 32'(bad), 32'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_char_ready", 32'(char_ready), 32'd1);
        chk("rst_vram_we",    32'(vram_we),    32'd0);
        chk("rst_vram_addr",  32'(vram_addr),  32'd0);
        chk("rst_vram_wdata", 32'(vram_wdata), 32'd0);
        chk("rst_cur_row",    32'(cur_row),    32'd0);
        chk("rst_cur_col",    32'(cur_col),    32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
    endtask

    function automatic logic [6:0] rand_print();
        return 7'($urandom_range(32, 126));
    endfunction

    initial begin
        int r;
        logic [6:0] c;
        for (int i = 0; i < CELLS; i++) begin
            tb_ram[i]  = rand_print();
            ref_mem[i] = tb_ram[i];
        end
        repeat (3) @(negedge sys_clk);
        check_reset_outputs();
        clrn = 1'b1;
        @(negedge sys_clk);

        // Single printable at home.
        send(7'h41);
        check_cursor(0, 1);

        // A full row of printables wraps to the next row.
        send(7'h0D);
        for (int i = 0; i < 80; i++) send(rand_print());
        check_cursor(1, 0);

        // Backspace mid-row, then at column 0.
        send(7'h0A);
        send(7'h0A);
        for (int i = 0; i < 5; i++) send(rand_print());
        check_cursor(3, 5);
        send(7'h08);
        check_cursor(3, 4);
        send(7'h0D);
        send(7'h08);
        check_cursor(3, 0);

        // Carriage return and an ignored code.
        for (int i = 0; i < 4; i++) send(7'h0A);
        for (int i = 0; i < 33; i++) send(rand_print());
        check_cursor(7, 33);
        send(7'h0D);
        check_cursor(7, 0);
        send(7'h01);
        check_cursor(7, 0);

        // Line feed on the last row scrolls.
        for (int i = 0; i < 52; i++) send(7'h0A);
        check_cursor(59, 0);
        send(7'h0A);
        check_cursor(59, 0);
        check_screen();

        // Printable in the bottom-right cell scrolls.
        for (int i = 0; i < 79; i++) send(rand_print());
        check_cursor(59, 79);
        send(7'h5A);
        check_cursor(59, 0);
        chk("cell_4719", 32'(tb_ram[4719]), 32'h5A);
        chk("cell_4799", 32'(tb_ram[4799]), 32'h20);
        check_screen();

        // Form feed, with a code held against the stall.
        send(7'h0C);
        send_held(7'h51);
        check_cursor(0, 1);
        check_screen();

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      c = rand_print();
            else if (r < 78) c = 7'h0A;
            else if (r < 84) c = 7'h0D;
            else if (r < 92) c = 7'h08;
            else begin
                c = 7'($urandom_range(0, 127));
                if (c == 7'h0C) c = 7'h01;
            end
            send(c);
            if (n % 25 == 24) check_cursor(ref_row, ref_col);
        end
        check_cursor(ref_row, ref_col);
        check_screen();

        // Reset in the middle of a clear.
        send(7'h0C);
        repeat (99) @(negedge sys_clk);
        #2 clrn = 1'b0;
        #1 check_reset_outputs();
        exp_wr.delete();
        exp_ready_run.delete();
        exp_busy_run.delete();
        ref_row = 0;
        ref_col = 0;
        @(negedge sys_clk);
        #2 clrn = 1'b1;
        @(negedge sys_clk);
        check_cursor(0, 0);
        send(7'h0C);
        send(7'h48);
        check_cursor(0, 1);
        check_screen();

        repeat (5) @(negedge sys_clk);
        chk("writes_outstanding", 32'(exp_wr.size()), 32'd0);
        chk("stalls_outstanding", 32'(exp_ready_run.size()), 32'd0);
        chk("busy_outstanding",   32'(exp_busy_run.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
